// File: rtl/spi_slave_pkg.sv
// Shared state encoding and command codes for the SPI slave.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRx,
    StWaitTx,
    StTx,
    StDone
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Only a read-data command waits for a reply word; everything else just finishes the frame.
  function automatic state_e state_after_rx(input logic [1:0] cmd);
    state_e nxt;
    case (cmd)
      CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR: nxt = StDone;
      CMD_RD_DATA:                           nxt = StWaitTx;
      default:                               nxt = StDone;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load serial shifter; direction chosen at elaboration.
module spi_shift_reg #(
  parameter int unsigned Width    = 8,
  parameter bit          MsbFirst = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic [Width-1:0] next_o
);

  logic [Width-1:0] data_q;

  // next_o is the value after one shift, so callers can capture a frame on its last bit.
  assign next_o = MsbFirst ? {data_q[Width-2:0], ser_i} : {ser_i, data_q[Width-1:1]};
  assign ser_o  = MsbFirst ? data_q[Width-1] : data_q[0];

  // Load has priority over shift.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= next_o;
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave: receives a command+payload frame, optionally returns one data word.
module spi_slave_param
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned TX_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mosi,
  input  logic              ss_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              miso,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned FrameW = DATA_W + 2;
  localparam int unsigned CntW   = $clog2(DATA_W + 3);
  localparam int unsigned WaitW  = $clog2(TX_TIMEOUT + 1);

  localparam logic [CntW-1:0]  RxLast   = CntW'(FrameW - 1);
  localparam logic [CntW-1:0]  TxLast   = CntW'(DATA_W - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TX_TIMEOUT - 1);

  state_e            state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [WaitW-1:0]  wait_cnt_q;
  logic [FrameW-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              frame_err_q;

  logic [FrameW-1:0] rx_next;
  logic [1:0]        rx_cmd;
  logic              rx_clear, rx_shift, tx_load, tx_shift, tx_ser;
  logic              rx_ser_unused;
  logic [DATA_W-1:0] tx_next_unused;

  // Shifter controls; tx inputs only matter while waiting for the reply word.
  assign rx_clear = (state_q == StIdle) && !ss_n;
  assign rx_shift = (state_q == StRx) && !ss_n;
  assign tx_load  = (state_q == StWaitTx) && !ss_n && tx_valid;
  assign tx_shift = (state_q == StTx) && !ss_n;
  assign rx_cmd   = rx_next[FrameW-1:FrameW-2];

  spi_shift_reg #(
    .Width    (FrameW),
    .MsbFirst (MSB_FIRST != 0)
  ) u_rx_shift (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (rx_clear),
    .load_data_i ('0),
    .shift_i     (rx_shift),
    .ser_i       (mosi),
    .ser_o       (rx_ser_unused),
    .next_o      (rx_next)
  );

  spi_shift_reg #(
    .Width    (DATA_W),
    .MsbFirst (MSB_FIRST != 0)
  ) u_tx_shift (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (tx_load),
    .load_data_i (tx_data),
    .shift_i     (tx_shift),
    .ser_i       (1'b0),
    .ser_o       (tx_ser),
    .next_o      (tx_next_unused)
  );

  // Frame sequencing; an ss_n deassert in any active phase aborts, even on the last rx bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!ss_n) begin
            state_q   <= StRx;
            bit_cnt_q <= '0;
          end
        end
        StRx: begin
          if (ss_n) begin
            state_q     <= StIdle;
            frame_err_q <= 1'b1;
            bit_cnt_q   <= '0;
          end else if (bit_cnt_q == RxLast) begin
            rx_data_q  <= rx_next;
            rx_valid_q <= 1'b1;
            state_q    <= state_after_rx(rx_cmd);
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        StWaitTx: begin
          if (ss_n) begin
            state_q     <= StIdle;
            frame_err_q <= 1'b1;
            wait_cnt_q  <= '0;
          end else if (tx_valid) begin
            state_q    <= StTx;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WaitLast) begin
            state_q     <= StDone;
            frame_err_q <= 1'b1;
            wait_cnt_q  <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StTx: begin
          if (ss_n) begin
            state_q     <= StIdle;
            frame_err_q <= 1'b1;
            bit_cnt_q   <= '0;
          end else if (bit_cnt_q == TxLast) begin
            state_q   <= StDone;
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (ss_n) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs come straight from registers so reset clears them without waiting for a clock.
  assign miso      = (state_q == StTx) & tx_ser;
  assign busy      = (state_q != StIdle);
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a frame-level model, plus literal expectations.
module tb_spi_slave_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic       m_miso, m_rv, m_busy, m_fe;
  logic [9:0] m_rd;
  logic       l_miso, l_rv, l_busy, l_fe;
  logic [9:0] l_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .MSB_FIRST(1), .TX_TIMEOUT(15)) dut_m (
    .clk(clk), .rst_n(rst_n), .mosi(mosi), .ss_n(ss_n), .tx_valid(tx_valid),
    .tx_data(tx_data), .miso(m_miso), .rx_valid(m_rv), .rx_data(m_rd), .busy(m_busy),
    .frame_err(m_fe)
  );

  spi_slave_param #(.DATA_W(8), .MSB_FIRST(0), .TX_TIMEOUT(15)) dut_l (
    .clk(clk), .rst_n(rst_n), .mosi(mosi), .ss_n(ss_n), .tx_valid(tx_valid),
    .tx_data(tx_data), .miso(l_miso), .rx_valid(l_rv), .rx_data(l_rd), .busy(l_busy),
    .frame_err(l_fe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model. Phase: 0 idle, 1 receiving, 2 awaiting reply, 3 replying, 4 finished.
  int ph[2]   = '{0, 0};
  int nb[2]   = '{0, 0};
  int acc[2]  = '{0, 0};
  int wcnt[2] = '{0, 0};
  int tcnt[2] = '{0, 0};
  int txw[2]  = '{0, 0};
  int e_rd[2] = '{0, 0};
  int e_rv[2] = '{0, 0};
  int e_fe[2] = '{0, 0};

  task automatic model_step(input int m);
    e_rv[m] = 0;
    e_fe[m] = 0;
    if (!rst_n) begin
      ph[m] = 0; nb[m] = 0; acc[m] = 0; wcnt[m] = 0; tcnt[m] = 0; txw[m] = 0; e_rd[m] = 0;
    end else begin
      case (ph[m])
        0: if (!ss_n) begin ph[m] = 1; nb[m] = 0; acc[m] = 0; end
        1: begin
          if (ss_n) begin
            ph[m] = 0; e_fe[m] = 1;
          end else begin
            if (m == 0) acc[m] = (acc[m] * 2 + int'(mosi)) % 1024;
            else        acc[m] = acc[m] + (int'(mosi) << nb[m]);
            nb[m]++;
            if (nb[m] == 10) begin
              e_rd[m] = acc[m];
              e_rv[m] = 1;
              ph[m]   = (acc[m] / 256 == 3) ? 2 : 4;
              wcnt[m] = 0;
            end
          end
        end
        2: begin
          if (ss_n) begin
            ph[m] = 0; e_fe[m] = 1;
          end else if (tx_valid) begin
            txw[m] = int'(tx_data); ph[m] = 3; tcnt[m] = 0;
          end else begin
            wcnt[m]++;
            if (wcnt[m] == 15) begin e_fe[m] = 1; ph[m] = 4; end
          end
        end
        3: begin
          if (ss_n) begin
            ph[m] = 0; e_fe[m] = 1;
          end else begin
            tcnt[m]++;
            if (tcnt[m] == 8) ph[m] = 4;
          end
        end
        default: if (ss_n) ph[m] = 0;
      endcase
    end
  endtask

  function automatic int exp_miso(input int m);
    if (ph[m] != 3) return 0;
    return (m == 0) ? ((txw[m] >> (7 - tcnt[m])) & 1) : ((txw[m] >> tcnt[m]) & 1);
  endfunction

  task automatic cmp_inst(input int m, input string p, input logic miso_v, input logic rv,
                          input logic [9:0] rd, input logic busy_v, input logic fe);
    chk({p, "_miso"}, miso_v, exp_miso(m));
    chk({p, "_rx_valid"}, rv, e_rv[m]);
    chk({p, "_rx_data"}, rd, e_rd[m]);
    chk({p, "_busy"}, busy_v, (ph[m] != 0) ? 1 : 0);
    chk({p, "_frame_err"}, fe, e_fe[m]);
  endtask

  // Advance the model on each edge, then compare just after the edge.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    cmp_inst(0, "msb", m_miso, m_rv, m_rd, m_busy, m_fe);
    cmp_inst(1, "lsb", l_miso, l_rv, l_rd, l_busy, l_fe);
  end

  // Called at a negedge; returns at the negedge after the last driven bit was sampled.
  task automatic send(input logic [9:0] seq, input int nbits);
    ss_n = 1'b0;
    mosi = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      mosi = seq[9-i];
    end
    @(negedge clk);
  endtask

  logic [7:0] got;
  int         fe_at;
  int         miso_seen;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_rx_data", m_rd, 10'h000);
    chk("reset_busy", m_busy, 1'b0);
    chk("reset_miso", m_miso, 1'b0);
    chk("reset_frame_err", m_fe, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write-style frame, both bit orders.
    send(10'b0010100101, 10);
    chk("t1_rx_valid", m_rv, 1'b1);
    chk("t1_rx_data", m_rd, 10'h0A5);
    chk("t1_lsb_rx_data", l_rd, 10'h294);
    repeat (3) begin
      @(negedge clk);
      chk("t1_done_busy", m_busy, 1'b1);
      chk("t1_done_no_valid", m_rv, 1'b0);
    end
    ss_n = 1'b1;
    @(negedge clk);
    chk("t1_idle_busy", m_busy, 1'b0);
    chk("t1_rx_data_held", m_rd, 10'h0A5);

    // Back-to-back frame; LSB-first ordering.
    send(10'b1010010110, 10);
    chk("t2_lsb_rx_data", l_rd, 10'h1A5);
    chk("t2_msb_rx_data", m_rd, 10'h296);
    ss_n = 1'b1;
    @(negedge clk);

    // Read-data reply with tx_valid two cycles after the frame.
    send(10'b1100000000, 10);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      got[7-i] = m_miso;
      @(negedge clk);
    end
    chk("t3_miso_seq", got, 8'hC3);
    chk("t3_miso_after", m_miso, 1'b0);
    chk("t3_done_busy", m_busy, 1'b1);
    ss_n = 1'b1;
    @(negedge clk);

    // Reply timeout.
    send(10'b1100000000, 10);
    fe_at = -1;
    miso_seen = 0;
    for (int k = 1; k <= 40 && fe_at < 0; k++) begin
      @(negedge clk);
      if (m_miso) miso_seen = 1;
      if (m_fe) fe_at = k;
    end
    chk("t4_timeout_cycles", fe_at, 15);
    chk("t4_miso_quiet", miso_seen, 0);
    chk("t4_done_busy", m_busy, 1'b1);
    ss_n = 1'b1;
    @(negedge clk);

    // Abort after five bits, then a good frame.
    send(10'b1111100000, 5);
    ss_n = 1'b1;
    @(negedge clk);
    chk("t5_abort_err", m_fe, 1'b1);
    chk("t5_abort_no_valid", m_rv, 1'b0);
    chk("t5_abort_idle", m_busy, 1'b0);
    chk("t5_lsb_abort_err", l_fe, 1'b1);
    send(10'b0110011001, 10);
    chk("t5_next_valid", m_rv, 1'b1);
    chk("t5_next_data", m_rd, 10'h199);
    ss_n = 1'b1;
    @(negedge clk);

    // Reset while replying.
    send(10'b1100000000, 10);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_miso", m_miso, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_miso", m_miso, 1'b0);
    chk("t6_reset_busy", m_busy, 1'b0);
    @(negedge clk);
    chk("t6_no_err", m_fe, 1'b0);
    ss_n  = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rx_data_cleared", m_rd, 10'h000);
    send(10'b0000001111, 10);
    chk("t6_fresh_valid", m_rv, 1'b1);
    chk("t6_fresh_data", m_rd, 10'h00F);
    ss_n = 1'b1;
    @(negedge clk);

    // Randomized frames: random bits, aborts, reply timing and hold lengths.
    for (int f = 0; f < 80; f++) begin
      int gap;
      int post;
      gap = $urandom_range(1, 3);
      ss_n = 1'b1;
      repeat (gap) @(negedge clk);
      ss_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        mosi = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 39) == 0) ss_n = 1'b1;
      end
      post = $urandom_range(0, 25);
      for (int j = 0; j < post; j++) begin
        @(negedge clk);
        tx_valid = ($urandom_range(0, 5) == 0);
        tx_data  = 8'($urandom);
        if ($urandom_range(0, 49) == 0) ss_n = 1'b1;
      end
      @(negedge clk);
      tx_valid = 1'b0;
    end

    ss_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-002 Parameter DATA_W SHALL default to 8: payload width in bits, legal range 4..16.
REQ-003 Parameter MSB_FIRST SHALL default to 1: 1 = MSB-first on mosi and miso, 0 = LSB-first.
REQ-004 Parameter TX_TIMEOUT SHALL default to 15: the maximum number of cycles spent waiting for tx_valid, legal range 1..255.
REQ-005 clk  input  1  SPI serial clock; all logic samples on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 mosi  input  1  serial data from the master.
REQ-008 ss_n  input  1  active-low slave select.
REQ-009 tx_valid  input  1  tx_data is valid.
REQ-010 tx_data  input  DATA_W  read data from memory.
REQ-011 miso  output  1  serial data to the master.
REQ-012 rx_valid  output  1  one-cycle pulse: rx_data holds a complete frame.
REQ-013 rx_data  output  DATA_W+2  frame; bits [DATA_W+1:DATA_W] are the command, the rest is the payload.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_err  output  1  one-cycle pulse on an aborted frame or a tx timeout.

Function
REQ-016 The state machine SHALL have exactly these states: IDLE, RX, WAIT_TX, TX, DONE.
REQ-017 IDLE SHALL go to RX at the edge where ss_n is sampled low; that edge does not sample mosi.
REQ-018 RX SHALL shift mosi in on each of the next DATA_W+2 edges, as follows:
- MSB_FIRST=1: the first bit lands at rx_data[DATA_W+1].
- MSB_FIRST=0: the first bit lands at bit 0.
REQ-019 At the edge that samples the last frame bit, rx_data SHALL update and rx_valid SHALL rise for exactly one cycle.
REQ-020 rx_data SHALL hold its value until the next completed frame.
REQ-021 After RX, the command SHALL select the next state:
- 00 or 01 (write address / write data): go to DONE.
- 10 (read address): go to DONE.
- 11 (read data): go to WAIT_TX.
REQ-022 In WAIT_TX, the first edge with tx_valid high SHALL load tx_data into the output shifter and go to TX.
REQ-023 In WAIT_TX, if tx_valid has not been seen within TX_TIMEOUT cycles, the block SHALL pulse frame_err and go to DONE.
REQ-024 TX SHALL drive miso for exactly DATA_W cycles, starting the cycle after the load, MSB or LSB first per MSB_FIRST, then go to DONE.
REQ-025 miso SHALL be 0 outside TX.
REQ-026 tx_valid and tx_data SHALL be ignored outside WAIT_TX.
REQ-027 DONE SHALL stay in DONE while ss_n is low and go to IDLE on the first edge with ss_n high.
REQ-028 ss_n sampled high in RX, WAIT_TX or TX SHALL abort: next state IDLE, frame_err pulses, and rx_valid does not pulse.
REQ-029 ss_n high at the same edge as the last RX bit SHALL count as an abort; the abort wins.
REQ-030 Bit counter width SHALL be $clog2(DATA_W+3); the counter resets to 0 on every state entry and never wraps within a state.
REQ-031 Back-to-back frames SHALL be supported: ss_n high for one cycle, then low, starts a new frame.

Reset
REQ-032 rst_n low SHALL force asynchronously: state IDLE, miso 0, rx_valid 0, rx_data 0, busy 0, frame_err 0, all counters and shifters 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame with no rx_valid and no frame_err pulse.
REQ-034 After reset release, the first ss_n-low edge SHALL start a fresh frame.

Structure
REQ-035 Package spi_slave_pkg SHALL hold the state enum and the command constants CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11.
REQ-036 Sub-module spi_shift_reg, parametrised on width and direction with load, shift and serial in/out, SHALL be instantiated twice: once for the rx path and once for the tx path.

Verification (DATA_W=8, MSB_FIRST=1 unless stated)
REQ-037 ss_n low, mosi 00_1010_0101 -> rx_valid pulses at the 11th edge after IDLE exit with rx_data=0x0A5; state DONE until ss_n high.
REQ-038 Frame 11_0000_0000, tx_valid high with tx_data=0xC3 two cycles later -> miso = 1,1,0,0,0,0,1,1 over 8 cycles, then 0.
REQ-039 Read-data frame with tx_valid never asserted -> frame_err pulses after 15 cycles in WAIT_TX; miso stays 0.
REQ-040 ss_n high after 5 RX bits -> frame_err pulse, no rx_valid, IDLE next cycle; the next full frame is received correctly.
REQ-041 MSB_FIRST=0, mosi bits 1,0,1,0,0,1,0,1,1,0 -> rx_data=0x1A5.
REQ-042 rst_n low during TX -> miso 0 and busy 0 immediately; no frame_err.
